data_read_unit: RTL and testbench

Read-return companion to the data transfer unit. It arbitrates memory read requests from the testbench port and the CPU/instruction port, drives the data memory read address, waits the memory's read latency and returns the captured byte to the requester. It sits between the two requesters and the 16-entry data memory, in parallel with the write path. It stalls new reads while a testbench write is in progress.

---
 rtl/dru_pkg.sv | 21 ++
 rtl/dru_arbiter.sv | 23 ++
 rtl/data_read_unit.sv | 111 +++++++++++
 tb/tb_data_read_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dru_pkg.sv
// Shared types and constants for the data read unit.
package dru_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   typedef enum logic {
      REQ_TB,
      REQ_CPU
   } req_id_t;

   localparam int DRU_ADDR_W     = 4;
   localparam int DRU_DATA_W     = 8;
   localparam int MAX_RD_LATENCY = 4;
   localparam int CNT_W          = $clog2(MAX_RD_LATENCY + 1);

endpackage

// File: rtl/dru_arbiter.sv
// Fixed-priority read arbiter: testbench port wins, writes stall both.
module dru_arbiter
   import dru_pkg::*;
(
   input  logic    idle,
   input  logic    mem_write_tb,
   input  logic    tb_rd_valid,
   input  logic    cpu_rd_valid,
   output logic    tb_rd_ready,
   output logic    cpu_rd_ready,
   output logic    grant,
   output req_id_t grant_id
);

   logic tb_win;

   assign tb_rd_ready  = idle && !mem_write_tb;
   assign cpu_rd_ready = idle && !mem_write_tb && !tb_rd_valid;
   assign tb_win       = tb_rd_valid && tb_rd_ready;
   assign grant        = tb_win || (cpu_rd_valid && cpu_rd_ready);
   assign grant_id     = tb_win ? REQ_TB : REQ_CPU;

endmodule

// File: rtl/data_read_unit.sv
// Read-return unit: arbitrates TB/CPU reads and returns memory data.
// Optional DRU_ADDR_CHECK_EN flags CPU addresses with nonzero upper bits.
module data_read_unit
   import dru_pkg::*;
#(
   parameter int ADDR_W     = DRU_ADDR_W,
   parameter int DATA_W     = DRU_DATA_W,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tb_rd_valid,
   input  logic [ADDR_W-1:0] tb_rd_addr,
   output logic              tb_rd_ready,
   output logic              tb_resp_valid,
   input  logic              cpu_rd_valid,
   input  logic [7:0]        cpu_rd_addr,
   output logic              cpu_rd_ready,
   output logic              cpu_resp_valid,
   output logic              cpu_resp_err,
   output logic [DATA_W-1:0] resp_data,
   input  logic              mem_write_tb,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data
);

   state_t           state;
   req_id_t          req;
   req_id_t          grant_id;
   logic [CNT_W-1:0] cnt;
   logic             idle;
   logic             grant;
   logic             addr_bad;

   assign idle = (state == IDLE);

`ifdef DRU_ADDR_CHECK_EN
   assign addr_bad = |cpu_rd_addr[7:ADDR_W];
`else
   logic unused_hi;
   assign addr_bad  = 1'b0;
   assign unused_hi = ^cpu_rd_addr[7:ADDR_W];
`endif

   dru_arbiter u_arb (
      .idle         (idle),
      .mem_write_tb (mem_write_tb),
      .tb_rd_valid  (tb_rd_valid),
      .cpu_rd_valid (cpu_rd_valid),
      .tb_rd_ready  (tb_rd_ready),
      .cpu_rd_ready (cpu_rd_ready),
      .grant        (grant),
      .grant_id     (grant_id)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         req            <= REQ_TB;
         cnt            <= '0;
         mem_rd_en      <= 1'b0;
         mem_rd_addr    <= '0;
         resp_data      <= '0;
         tb_resp_valid  <= 1'b0;
         cpu_resp_valid <= 1'b0;
         cpu_resp_err   <= 1'b0;
      end else begin
         mem_rd_en      <= 1'b0;
         tb_resp_valid  <= 1'b0;
         cpu_resp_valid <= 1'b0;
         cpu_resp_err   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant) begin
                  req <= grant_id;
                  // Bad CPU address: answer at once, never touch memory
                  if (grant_id == REQ_CPU && addr_bad) begin
                     resp_data      <= '0;
                     cpu_resp_valid <= 1'b1;
                     cpu_resp_err   <= 1'b1;
                     state          <= RESP;
                  end else begin
                     mem_rd_addr <= (grant_id == REQ_TB) ?
                                    tb_rd_addr :
                                    cpu_rd_addr[ADDR_W-1:0];
                     mem_rd_en   <= 1'b1;
                     state       <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               cnt   <= CNT_W'(RD_LATENCY);
               state <= WAIT;
            end
            WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  resp_data      <= mem_rd_data;
                  tb_resp_valid  <= (req == REQ_TB);
                  cpu_resp_valid <= (req == REQ_CPU);
                  state          <= RESP;
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_read_unit.sv
// Bench for data_read_unit: L=1 instance vs. transaction model, L=4 directed.
module tb_data_read_unit;

`ifdef DRU_ADDR_CHECK_EN
   localparam bit ADDR_CHK = 1'b1;
`else
   localparam bit ADDR_CHK = 1'b0;
`endif
   localparam int LA = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mem [16];

   // instance A: RD_LATENCY=1
   logic       a_rst, a_tbv, a_cpuv, a_wr;
   logic [3:0] a_tba;
   logic [7:0] a_cpua;
   logic       a_tbr, a_cpur, a_tv, a_cv, a_err, a_en;
   logic [7:0] a_data, a_mdata;
   logic [3:0] a_ad;

   // instance B: RD_LATENCY=4
   logic       b_rst, b_tbv, b_cpuv, b_wr;
   logic [3:0] b_tba;
   logic [7:0] b_cpua;
   logic       b_tbr, b_cpur, b_tv, b_cv, b_err, b_en;
   logic [7:0] b_data, b_mdata;
   logic [3:0] b_ad;

   data_read_unit #(.RD_LATENCY(1)) u_a (
      .clk(clk), .rst(a_rst),
      .tb_rd_valid(a_tbv), .tb_rd_addr(a_tba), .tb_rd_ready(a_tbr),
      .tb_resp_valid(a_tv),
      .cpu_rd_valid(a_cpuv), .cpu_rd_addr(a_cpua), .cpu_rd_ready(a_cpur),
      .cpu_resp_valid(a_cv), .cpu_resp_err(a_err),
      .resp_data(a_data), .mem_write_tb(a_wr),
      .mem_rd_en(a_en), .mem_rd_addr(a_ad), .mem_rd_data(a_mdata)
   );

   data_read_unit #(.RD_LATENCY(4)) u_b (
      .clk(clk), .rst(b_rst),
      .tb_rd_valid(b_tbv), .tb_rd_addr(b_tba), .tb_rd_ready(b_tbr),
      .tb_resp_valid(b_tv),
      .cpu_rd_valid(b_cpuv), .cpu_rd_addr(b_cpua), .cpu_rd_ready(b_cpur),
      .cpu_resp_valid(b_cv), .cpu_resp_err(b_err),
      .resp_data(b_data), .mem_write_tb(b_wr),
      .mem_rd_en(b_en), .mem_rd_addr(b_ad), .mem_rd_data(b_mdata)
   );

   // memories: data valid exactly L cycles after the strobe, junk otherwise
   always @(posedge clk) begin
      if (a_en) a_mdata <= mem[a_ad];
      else      a_mdata <= 8'($urandom);
   end

   logic [3:0] p_en = '0;
   logic [3:0] p_ad [3];
   always @(posedge clk) begin
      p_en     <= {p_en[2:0], b_en};
      p_ad[0]  <= b_ad;
      p_ad[1]  <= p_ad[0];
      p_ad[2]  <= p_ad[1];
      if (p_en[2]) b_mdata <= mem[p_ad[2]];
      else         b_mdata <= 8'($urandom);
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp,
                  $time);
      end
   endtask

   // transaction-level model of instance A
   typedef struct {
      bit         tb;
      bit         cpu;
      bit         err;
      logic [7:0] d;
   } resp_t;

   logic [3:0] iss [int];
   resp_t      rsp [int];
   int         cyc = 0;
   int         free_at = 0;
   logic [3:0] last_addr = '0;
   logic [7:0] last_data = '0;

   task automatic step(output bit acc);
      bit rt, rc, tbw;
      logic [3:0] a;
      resp_t r;
      int n;
      #1;
      n  = cyc;
      rt = (n >= free_at) && !a_wr;
      rc = rt && !a_tbv;
      chk("tb_rd_ready", a_tbr, rt);
      chk("cpu_rd_ready", a_cpur, rc);
      if (iss.exists(n)) last_addr = iss[n];
      chk("mem_rd_en", a_en, iss.exists(n));
      chk("mem_rd_addr", a_ad, last_addr);
      r = '{tb: 1'b0, cpu: 1'b0, err: 1'b0, d: 8'h00};
      if (rsp.exists(n)) begin
         r = rsp[n];
         last_data = r.d;
      end
      chk("tb_resp_valid", a_tv, r.tb);
      chk("cpu_resp_valid", a_cv, r.cpu);
      chk("resp_data", a_data, last_data);
      if (r.cpu) chk("cpu_resp_err", a_err, r.err);
      acc = 1'b0;
      tbw = 1'b0;
      a   = '0;
      if (rt && a_tbv) begin
         acc = 1'b1; tbw = 1'b1; a = a_tba;
      end else if (rc && a_cpuv) begin
         acc = 1'b1; a = a_cpua[3:0];
      end
      if (acc) begin
         if (!tbw && ADDR_CHK && a_cpua[7:4] != 4'h0) begin
            rsp[n+1] = '{tb: 1'b0, cpu: 1'b1, err: 1'b1, d: 8'h00};
            free_at  = n + 2;
         end else begin
            iss[n+1]    = a;
            rsp[n+LA+2] = '{tb: tbw, cpu: !tbw, err: 1'b0, d: mem[a]};
            free_at     = n + LA + 3;
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   typedef struct {
      logic tbv, cpuv, wr;
      logic tbr, cpur;
   } vec_t;

   vec_t vt [8];

   initial begin
      bit acc, got, en_seen, cv_seen, err_seen;
      int t0, t1;
      logic [7:0] d_seen;

      vt[0] = '{0,0,0, 1,1};
      vt[1] = '{1,0,0, 1,0};
      vt[2] = '{0,1,0, 1,1};
      vt[3] = '{1,1,0, 1,0};
      vt[4] = '{0,0,1, 0,0};
      vt[5] = '{1,0,1, 0,0};
      vt[6] = '{0,1,1, 0,0};
      vt[7] = '{1,1,1, 0,0};

      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      a_rst = 1; a_tbv = 0; a_cpuv = 0; a_wr = 0; a_tba = 0; a_cpua = 0;
      b_rst = 1; b_tbv = 0; b_cpuv = 0; b_wr = 0; b_tba = 0; b_cpua = 0;
      repeat (2) @(negedge clk);
      chk("rst_en", b_en, 0);
      chk("rst_addr", b_ad, 0);
      chk("rst_data", b_data, 0);
      chk("rst_valids", {b_tv, b_cv, b_err}, 0);
      a_rst = 0;
      b_rst = 0;

      // ready table on idle instance B; valids dropped before the edge
      for (int i = 0; i < 8; i++) begin
         b_tbv = vt[i].tbv; b_cpuv = vt[i].cpuv; b_wr = vt[i].wr;
         #1;
         chk($sformatf("tbl%0d_tb_ready", i), b_tbr, vt[i].tbr);
         chk($sformatf("tbl%0d_cpu_ready", i), b_cpur, vt[i].cpur);
         #1;
         b_tbv = 0; b_cpuv = 0; b_wr = 0;
         @(negedge clk);
      end

      // single CPU read
      mem[5] = 8'hA7;
      a_cpuv = 1; a_cpua = 8'h05;
      step(acc);
      a_cpuv = 0;
      repeat (5) step(acc);

      // simultaneous requests
      mem[2] = 8'h11; mem[3] = 8'h22;
      a_tbv = 1; a_tba = 4'd2; a_cpuv = 1; a_cpua = 8'h03;
      t0 = cyc;
      step(acc);
      a_tbv = 0;
      t1 = -1;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         step(acc);
         if (acc) begin got = 1; t1 = cyc - 1; end
      end
      a_cpuv = 0;
      chk("sim_cpu_accept_gap", t1 - t0, LA + 3);
      repeat (6) step(acc);

      // write stall
      a_wr = 1; a_cpuv = 1; a_cpua = 8'h07;
      repeat (5) step(acc);
      a_wr = 0;
      #1 chk("stall_release_ready", a_cpur, 1);
      step(acc);
      a_cpuv = 0;
      repeat (5) step(acc);

      // address check
      mem[5] = 8'h5C;
      a_cpuv = 1; a_cpua = 8'h35;
      step(acc);
      a_cpuv = 0;
      en_seen = 0; cv_seen = 0; err_seen = 0; d_seen = 8'hEE;
      for (int i = 0; i < 5; i++) begin
         en_seen |= a_en;
         if (a_cv) begin cv_seen = 1; err_seen = a_err; d_seen = a_data; end
         step(acc);
      end
      chk("addrchk_rd_en_seen", en_seen, ADDR_CHK ? 0 : 1);
      chk("addrchk_resp_seen", cv_seen, 1);
      chk("addrchk_err", err_seen, ADDR_CHK ? 1 : 0);
      chk("addrchk_data", d_seen, ADDR_CHK ? 8'h00 : 8'h5C);

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         a_tbv  = ($urandom % 4) == 0;
         a_tba  = 4'($urandom);
         a_cpuv = 1'($urandom);
         a_cpua = (($urandom % 4) == 0) ? 8'($urandom) : {4'h0, 4'($urandom)};
         a_wr   = ($urandom % 6) == 0;
         step(acc);
      end
      a_tbv = 0; a_cpuv = 0; a_wr = 0;
      repeat (6) step(acc);

      // latency sweep on B (L=4)
      mem[15] = 8'hFF;
      b_tbv = 1; b_tba = 4'd15;
      #1 chk("b_ready0", b_tbr, 1);
      @(negedge clk);
      b_tbv = 0;
      #1;
      chk("b_issue_en", b_en, 1);
      chk("b_issue_addr", b_ad, 15);
      for (int k = 2; k <= 5; k++) begin
         @(negedge clk);
         #1 chk($sformatf("b_no_resp_c%0d", k), {b_tv, b_cv, b_en}, 0);
      end
      @(negedge clk);
      #1;
      chk("b_resp_valid", b_tv, 1);
      chk("b_resp_data", b_data, 8'hFF);
      chk("b_cpu_valid", b_cv, 0);
      @(negedge clk);
      #1 chk("b_ready_again", b_tbr, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1 chk("b_data_hold", b_data, 8'hFF);
      end

      // reset asserted mid-WAIT on B
      mem[9] = 8'h3C;
      @(negedge clk);
      b_cpuv = 1; b_cpua = 8'h09;
      @(negedge clk);
      b_cpuv = 0;
      repeat (2) @(negedge clk);
      #2 b_rst = 1;
      #1;
      chk("mid_rst_en", b_en, 0);
      chk("mid_rst_addr", b_ad, 0);
      chk("mid_rst_data", b_data, 0);
      chk("mid_rst_valids", {b_tv, b_cv, b_err}, 0);
      @(negedge clk);
      b_rst = 0;
      got = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         got |= b_tv | b_cv;
      end
      chk("mid_rst_no_resp", got, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
